// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder slice.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    COLLECT = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_A   = 8'd65;
  localparam logic [7:0] CHAR_Z   = 8'd90;
  localparam logic [7:0] CHAR_END = 8'd36;

endpackage

// File: rtl/rle_run_tracker.sv
// Tracks the current run (char, count) and strobes out a closed run.
// emit/emit_char/emit_cnt are combinational; the top registers them.
module rle_run_tracker
  import rle_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume,
  input  logic             flush,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic             emit,
  output logic [7:0]       emit_char,
  output logic [CNT_W-1:0] emit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       cur_char;
  logic [CNT_W-1:0] cur_cnt;
  logic             have_run;
  logic             close_run;

  // A run closes on a different char or when the counter is saturated.
  always_comb begin
    close_run = have_run && consume && ((data != cur_char) || (cur_cnt == CNT_MAX));
    emit      = close_run || (flush && have_run);
    emit_char = cur_char;
    emit_cnt  = cur_cnt;
  end

  // Run state: load, extend, or restart on each consumed character.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_char <= '0;
      cur_cnt  <= '0;
      have_run <= 1'b0;
    end else if (clear) begin
      cur_cnt  <= '0;
      have_run <= 1'b0;
    end else if (consume) begin
      have_run <= 1'b1;
      cur_char <= data;
      if (have_run && !close_run)
        cur_cnt <= cur_cnt + CNT_W'(1);
      else
        cur_cnt <= CNT_W'(1);
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder fed by the letter-buffer FIFO.
// Optional macro RLE_CHECKSUM_EN adds rle_sum, a mod-256 sum of the batch.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready_fifo,
  input  logic             valid_fifo,
  input  logic             done_fifo,
  input  logic [7:0]       fifo_data,
  output logic             rle_valid,
  output logic [7:0]       rle_char,
  output logic [CNT_W-1:0] rle_count,
  output logic             rle_done,
`ifdef RLE_CHECKSUM_EN
  output logic [7:0]       rle_sum,
`endif
  output logic             busy
);

  state_t           state, next_state;
  logic             consume, flush, clear;
  logic             emit;
  logic [7:0]       emit_char;
  logic [CNT_W-1:0] emit_cnt;
  logic             ready_d, busy_d, done_d;

  assign consume = (state == COLLECT) && valid_fifo;
  assign flush   = (state == COLLECT) && done_fifo;
  assign clear   = (state == DONE);

  rle_run_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .consume   (consume),
    .flush     (flush),
    .clear     (clear),
    .data      (fifo_data),
    .emit      (emit),
    .emit_char (emit_char),
    .emit_cnt  (emit_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     next_state = COLLECT;
      COLLECT: if (done_fifo) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from next_state so the registered copies line up with state.
  // The final pair is closed on done_fifo, so it is visible during FLUSH.
  always_comb begin
    ready_d = (next_state == REQ);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_fifo <= 1'b0;
      busy       <= 1'b0;
      rle_done   <= 1'b0;
      rle_valid  <= 1'b0;
      rle_char   <= '0;
      rle_count  <= '0;
    end else begin
      ready_fifo <= ready_d;
      busy       <= busy_d;
      rle_done   <= done_d;
      rle_valid  <= emit;
      rle_char   <= emit ? emit_char : '0;
      rle_count  <= emit ? emit_cnt  : '0;
    end
  end

`ifdef RLE_CHECKSUM_EN
  // Batch checksum: cleared on request, accumulates every consumed char.
  always_ff @(posedge clk) begin
    if (rst)                rle_sum <= '0;
    else if (state == REQ)  rle_sum <= '0;
    else if (consume)       rle_sum <= rle_sum + fifo_data;
  end
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: CNT_W=4 and CNT_W=2 instances share stimulus.
module tb_rle_encoder;
  import rle_pkg::*;

  typedef struct {
    int cyc;
    int ch;
    int cnt;
  } ev_t;

  logic clk, rst, start, valid_fifo, done_fifo;
  logic [7:0] fifo_data;
  logic r4, v4, d4, b4, r2, v2, d2, b2;
  logic [7:0] c4, c2;
  logic [3:0] n4;
  logic [1:0] n2;
`ifdef RLE_CHECKSUM_EN
  logic [7:0] sum4, sum2;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  ev_t g4[$], g2[$], e4[$], e2[$];
  int  dn4[$], dn2[$], feed[$];

  rle_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ready_fifo(r4),
    .valid_fifo(valid_fifo), .done_fifo(done_fifo), .fifo_data(fifo_data),
    .rle_valid(v4), .rle_char(c4), .rle_count(n4), .rle_done(d4),
`ifdef RLE_CHECKSUM_EN
    .rle_sum(sum4),
`endif
    .busy(b4)
  );

  rle_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .ready_fifo(r2),
    .valid_fifo(valid_fifo), .done_fifo(done_fifo), .fifo_data(fifo_data),
    .rle_valid(v2), .rle_char(c2), .rle_count(n2), .rle_done(d2),
`ifdef RLE_CHECKSUM_EN
    .rle_sum(sum2),
`endif
    .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output log, sampled 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (v4) g4.push_back('{cyc, int'(c4), int'(n4)});
      if (v2) g2.push_back('{cyc, int'(c2), int'(n2)});
      if (d4) dn4.push_back(cyc);
      if (d2) dn2.push_back(cyc);
    end
  end

  always @(posedge clk)
    if (!rst) assert (!(valid_fifo && done_fifo))
      else $error("protocol violation: valid_fifo and done_fifo both high");

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic exp_clear();
    e4.delete();
    e2.delete();
  endtask

  task automatic exp_both(input int ch, input int cnt, input int pos);
    e4.push_back('{pos, ch, cnt});
    e2.push_back('{pos, ch, cnt});
  endtask

  task automatic clear_logs();
    g4.delete(); g2.delete(); dn4.delete(); dn2.delete(); feed.delete();
  endtask

  task automatic compare(input string name);
    check({name, ":npairs4"}, g4.size(), e4.size());
    for (int i = 0; i < e4.size() && i < g4.size(); i++) begin
      check({name, ":char4"}, g4[i].ch,  e4[i].ch);
      check({name, ":cnt4"},  g4[i].cnt, e4[i].cnt);
      check({name, ":cyc4"},  g4[i].cyc, feed[e4[i].cyc]);
    end
    check({name, ":npairs2"}, g2.size(), e2.size());
    for (int i = 0; i < e2.size() && i < g2.size(); i++) begin
      check({name, ":char2"}, g2[i].ch,  e2[i].ch);
      check({name, ":cnt2"},  g2[i].cnt, e2[i].cnt);
      check({name, ":cyc2"},  g2[i].cyc, feed[e2[i].cyc]);
    end
    check({name, ":ndone4"}, dn4.size(), 1);
    check({name, ":ndone2"}, dn2.size(), 1);
    if (dn4.size() > 0) check({name, ":done_cyc4"}, dn4[0], feed[feed.size()-1] + 1);
    if (dn2.size() > 0) check({name, ":done_cyc2"}, dn2[0], feed[feed.size()-1] + 1);
  endtask

  task automatic wait_ready(input string name);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (r4) seen = 1;
      else @(negedge clk);
    end
    check({name, ":ready4"}, seen, 1);
    check({name, ":ready2"}, r2, 1);
  endtask

  task automatic run_batch(input string s, input bit hold);
    bit seen;
    logic [7:0] ch;
    logic [7:0] esum = '0;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    wait_ready(s);
    if (!hold) start = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ch = s[i];
      feed.push_back(cyc + 1);
      if (ch == CHAR_END) begin
        valid_fifo = 1'b0;
        done_fifo  = 1'b1;
      end else begin
        assert (ch >= CHAR_A && ch <= CHAR_Z);
        valid_fifo = 1'b1;
        fifo_data  = ch;
        esum       = esum + ch;
      end
    end
    @(negedge clk);
    valid_fifo = 1'b0;
    done_fifo  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (dn4.size() > 0) seen = 1;
      else @(negedge clk);
    end
    check({s, ":done_seen"}, seen, 1);
`ifdef RLE_CHECKSUM_EN
    check({s, ":sum4"}, sum4, esum);
    check({s, ":sum2"}, sum2, esum);
`else
    check({s, ":done_lvl"}, d4, 1);
    if (esum == 8'hFF) check({s, ":esum"}, esum, 8'hFF);
`endif
    compare(s);
    @(negedge clk);
    check({s, ":busy4_idle"}, b4, 0);
    check({s, ":busy2_idle"}, b2, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid_fifo = 1'b0; done_fifo = 1'b0; fifo_data = '0;
    repeat (3) @(negedge clk);
    check("rst:ready", r4, 0);
    check("rst:valid", v4, 0);
    check("rst:char",  c4, 0);
    check("rst:count", n4, 0);
    check("rst:done",  d4, 0);
    check("rst:busy",  b4, 0);
    check("rst:busy2", b2, 0);
    rst = 1'b0;
    @(negedge clk);

    exp_clear(); exp_both(65, 2, 2); exp_both(66, 1, 3);
    run_batch("AAB$", 1'b0);

    exp_clear();
    run_batch("$", 1'b0);

    exp_clear();
    e4.push_back('{5, 65, 5});
    e2.push_back('{3, 65, 3});
    e2.push_back('{5, 65, 2});
    run_batch("AAAAA$", 1'b0);

    exp_clear(); exp_both(65, 1, 1); exp_both(66, 1, 2); exp_both(65, 1, 3);
    run_batch("ABA$", 1'b0);

    // Reset in the middle of a run, then a stray valid while idle.
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    wait_ready("midrst");
    start = 1'b0;
    @(negedge clk); valid_fifo = 1'b1; fifo_data = 8'd65;
    @(negedge clk); fifo_data = 8'd65;
    @(negedge clk); valid_fifo = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst:busy", b4, 0);
    @(negedge clk); valid_fifo = 1'b1; fifo_data = 8'd81;
    @(negedge clk); valid_fifo = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst:npairs4", g4.size(), 0);
    check("midrst:npairs2", g2.size(), 0);
    check("midrst:ndone4", dn4.size(), 0);
    check("midrst:ndone2", dn2.size(), 0);
    check("midrst:busy_end", b4, 0);

    exp_clear(); exp_both(67, 1, 1);
    run_batch("C$", 1'b0);

    exp_clear(); exp_both(90, 2, 2);
    run_batch("ZZ$", 1'b1);
    exp_clear(); exp_both(66, 1, 1);
    run_batch("B$", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
